// File: rtl/wb_snoop_ctrl.sv
// Snoop-side sequencer: broadcasts a granted request to the other cores,
// gathers poll responses under a timeout, then serves a hit or hands off to memory.
module wb_snoop_ctrl #(
    parameter int aw        = 32,
    parameter int dw        = 32,
    parameter int num_cores = 2,
    parameter int timeout   = 16,
    localparam int cs       = (num_cores > 1) ? $clog2(num_cores) : 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [cs-1:0]           req_core_i,
    input  logic                    req_we_i,
    input  logic [aw-1:0]           req_adr_i,
    output logic [aw-1:0]           snoop_adr_o,
    output logic                    snoop_inv_o,
    output logic [num_cores-1:0]    poll_active_o,
    input  logic [num_cores-1:0]    poll_valid_i,
    input  logic [num_cores-1:0]    poll_hit_i,
    input  logic [num_cores*dw-1:0] snooped_dat_i,
    output logic                    mem_req_o,
    input  logic                    mem_done_i,
    output logic                    done_o,
    output logic                    hit_o,
    output logic [cs-1:0]           hit_core_o,
    output logic [dw-1:0]           hit_dat_o,
    output logic                    timeout_o
);

    localparam int tw = $clog2(timeout + 1);

    typedef enum logic [2:0] {
        IDLE,
        POLL,
        HIT,
        MEM,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [aw-1:0]          adr_q, adr_d;
    logic [cs-1:0]          core_q, core_d;
    logic                   we_q, we_d;
    logic [num_cores-1:0]   resp_q, resp_d;
    logic [tw-1:0]          timer_q, timer_d;
    logic                   to_q, to_d;
    logic [cs-1:0]          hcore_q, hcore_d;
    logic [dw-1:0]          hdat_q, hdat_d;
    logic                   ready_q, ready_d;

    logic [num_cores-1:0]   poll_mask;
    logic [num_cores-1:0]   hits;
    logic [cs-1:0]          hit_idx;
    logic [dw-1:0]          hit_slice;

    // Poll mask is every core except the requester; empty with a single core.
    always_comb begin
        poll_mask = '0;
        for (int i = 0; i < num_cores; i++) begin
            poll_mask[i] = (num_cores > 1) && (cs'(i) != core_q);
        end
        hits      = poll_valid_i & poll_hit_i & poll_mask;
        hit_idx   = '0;
        hit_slice = '0;
        for (int i = num_cores - 1; i >= 0; i--) begin
            if (hits[i]) begin
                hit_idx   = cs'(i);
                hit_slice = snooped_dat_i[i*dw +: dw];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        core_d  = core_q;
        we_d    = we_q;
        resp_d  = resp_q;
        timer_d = timer_q;
        to_d    = to_q;
        hcore_d = hcore_q;
        hdat_d  = hdat_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i && ready_q) begin
                    adr_d   = req_adr_i;
                    core_d  = req_core_i;
                    we_d    = req_we_i;
                    resp_d  = '0;
                    timer_d = '0;
                    to_d    = 1'b0;
                    state_d = (num_cores > 1) ? POLL : MEM;
                end
            end
            POLL: begin
                resp_d = resp_q | (poll_valid_i & poll_mask);
                if (!we_q && (|hits)) begin
                    hcore_d = hit_idx;
                    hdat_d  = hit_slice;
                    state_d = HIT;
                end else if (resp_d == poll_mask) begin
                    state_d = MEM;
                end else if (timer_q == tw'(timeout - 1)) begin
                    to_d    = 1'b1;
                    state_d = MEM;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HIT:  state_d = IDLE;
            MEM:  if (mem_done_i) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Registered so ready stays low through the reset cycles themselves.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            core_q  <= '0;
            we_q    <= 1'b0;
            resp_q  <= '0;
            timer_q <= '0;
            to_q    <= 1'b0;
            hcore_q <= '0;
            hdat_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            core_q  <= core_d;
            we_q    <= we_d;
            resp_q  <= resp_d;
            timer_q <= timer_d;
            to_q    <= to_d;
            hcore_q <= hcore_d;
            hdat_q  <= hdat_d;
            ready_q <= ready_d;
        end
    end

    assign req_ready_o   = ready_q;
    assign snoop_adr_o   = adr_q;
    assign snoop_inv_o   = (state_q == POLL) && we_q;
    assign poll_active_o = (state_q == POLL) ? poll_mask : '0;
    assign mem_req_o     = (state_q == MEM);
    assign done_o        = (state_q == HIT) || (state_q == DONE);
    assign hit_o         = (state_q == HIT);
    assign hit_core_o    = (state_q == HIT) ? hcore_q : '0;
    assign hit_dat_o     = (state_q == HIT) ? hdat_q : '0;
    assign timeout_o     = (state_q == DONE) && to_q;

endmodule

// File: tb/tb_wb_snoop_ctrl.sv
// Scoreboard bench for wb_snoop_ctrl: 4-core instance under directed and random
// transactions against a response-schedule model, plus a single-core instance.
module tb_wb_snoop_ctrl;

    localparam int NC = 4;
    localparam int TO = 8;
    localparam int NEVER = 99;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           req_valid = 1'b0;
    logic           ready;
    logic [1:0]     req_core = '0;
    logic           req_we = 1'b0;
    logic [31:0]    req_adr = '0;
    logic [31:0]    snoop_adr;
    logic           snoop_inv;
    logic [NC-1:0]  poll_active;
    logic [NC-1:0]  poll_valid = '0;
    logic [NC-1:0]  poll_hit = '0;
    logic [NC*32-1:0] sdat = '0;
    logic           mem_req;
    logic           mem_done = 1'b0;
    logic           done;
    logic           hit;
    logic [1:0]     hit_core;
    logic [31:0]    hit_dat;
    logic           to_flag;

    wb_snoop_ctrl #(.aw(32), .dw(32), .num_cores(NC), .timeout(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(ready),
        .req_core_i(req_core), .req_we_i(req_we), .req_adr_i(req_adr),
        .snoop_adr_o(snoop_adr), .snoop_inv_o(snoop_inv),
        .poll_active_o(poll_active), .poll_valid_i(poll_valid),
        .poll_hit_i(poll_hit), .snooped_dat_i(sdat),
        .mem_req_o(mem_req), .mem_done_i(mem_done),
        .done_o(done), .hit_o(hit), .hit_core_o(hit_core),
        .hit_dat_o(hit_dat), .timeout_o(to_flag)
    );

    logic        rv1 = 1'b0, rdy1, we1 = 1'b0, sinv1, mr1, md1 = 1'b0;
    logic        dn1, h1, to1;
    logic [0:0]  rc1 = '0, pa1, hc1;
    logic [31:0] adr1 = '0, sadr1, hd1;

    wb_snoop_ctrl #(.aw(32), .dw(32), .num_cores(1), .timeout(4)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .req_valid_i(rv1), .req_ready_o(rdy1),
        .req_core_i(rc1), .req_we_i(we1), .req_adr_i(adr1),
        .snoop_adr_o(sadr1), .snoop_inv_o(sinv1),
        .poll_active_o(pa1), .poll_valid_i(1'b0),
        .poll_hit_i(1'b0), .snooped_dat_i(32'h0),
        .mem_req_o(mr1), .mem_done_i(md1),
        .done_o(dn1), .hit_o(h1), .hit_core_o(hc1),
        .hit_dat_o(hd1), .timeout_o(to1)
    );

    typedef struct {
        bit          hit;
        int          core;
        logic [31:0] dat;
        bit          to;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory side: completes after mem_d cycles of mem_req (0 = never).
    int mem_d = 1;
    int mcnt = 0;
    always @(negedge clk) begin
        if (!rst_n || !mem_req) begin
            mcnt = 0;
            mem_done = 1'b0;
        end else begin
            mcnt++;
            mem_done = (mem_d > 0) && (mcnt == mem_d);
        end
    end

    bit mem_seen = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            mem_seen = 0;
        end else begin
            if (mem_req) mem_seen = 1;
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done_o=1 expected no completion (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("hit", hit, e.hit);
                    if (e.hit) begin
                        chk("hit_core", hit_core, e.core);
                        chk("hit_dat", hit_dat, e.dat);
                    end
                    chk("timeout", to_flag, e.to);
                    chk("mem_used", mem_seen, !e.hit);
                    chk("done_cycle", cyc, e.cyc);
                end
                mem_seen = 0;
            end
        end
    end

    // Outcome from the per-core response schedule: the edge (1-based after
    // acceptance) of the first hit, of the last poll response, or the timeout.
    function automatic void model(input int core, input bit we,
                                  input int r[NC], input bit h[NC],
                                  input logic [31:0] d[NC],
                                  output exp_t e, output int k);
        int kh = NEVER;
        int ka = 0;
        bit all = 1;
        e.hit = 0; e.core = 0; e.dat = '0; e.to = 0; e.cyc = 0;
        for (int i = 0; i < NC; i++) begin
            if (i == core) continue;
            if (r[i] > TO) all = 0;
            else if (r[i] > ka) ka = r[i];
            if (!we && h[i] && r[i] <= TO && r[i] < kh) begin
                kh = r[i];
                e.core = i;
                e.dat = d[i];
            end
        end
        if (kh <= TO && (!all || kh <= ka)) begin
            e.hit = 1;
            k = kh;
        end else if (all) begin
            k = ka;
        end else begin
            e.to = 1;
            k = TO;
        end
    endfunction

    task automatic run(input int core, input bit we, input logic [31:0] adr,
                       input int r[NC], input bit h[NC], input logic [31:0] d[NC],
                       input int memd, input bit expect_done);
        exp_t e;
        int k, t, n;
        int dur[NC];
        logic [NC-1:0] mask;
        for (int i = 0; i < NC; i++) dur[i] = $urandom_range(1, 3);
        mask = '1;
        mask[core] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: got req_ready_o=0 expected 1 within 100 cycles");
            return;
        end
        mem_d = memd;
        req_valid = 1'b1;
        req_core = core[1:0];
        req_we = we;
        req_adr = adr;
        t = cyc + 1;
        model(core, we, r, h, d, e, k);
        e.cyc = e.hit ? t + k : t + k + memd;
        if (expect_done) q.push_back(e);
        for (int kk = 1; kk <= TO + 1; kk++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (kk == 1) begin
                chk("ready_busy", ready, 0);
                chk("snoop_adr", snoop_adr, adr);
            end
            if (kk <= k) begin
                chk("poll_active", poll_active, mask);
                chk("snoop_inv", snoop_inv, we);
            end else if (kk == k + 1) begin
                chk("poll_end", poll_active, 0);
            end
            for (int i = 0; i < NC; i++) begin
                sdat[i*32 +: 32] = d[i];
                if (i == core) begin
                    poll_valid[i] = 1'($urandom_range(0, 1));
                    poll_hit[i]   = 1'($urandom_range(0, 1));
                end else begin
                    poll_valid[i] = (kk >= r[i]) && (kk < r[i] + dur[i]);
                    poll_hit[i]   = h[i];
                end
            end
        end
        @(negedge clk);
        poll_valid = '0;
        poll_hit = '0;
    endtask

    int r[NC];
    bit h[NC];
    logic [31:0] d[NC];

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_poll_active", poll_active, 0);
        chk("rst_snoop_adr", snoop_adr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", ready, 1);
        chk("ready1_after_rst", rdy1, 1);

        // single core: straight to memory, no polling
        rv1 = 1'b1;
        adr1 = 32'h0000_0240;
        @(negedge clk);
        rv1 = 1'b0;
        chk("nc1_poll_active", pa1, 0);
        chk("nc1_mem_req", mr1, 1);
        chk("nc1_ready", rdy1, 0);
        md1 = 1'b1;
        @(negedge clk);
        md1 = 1'b0;
        chk("nc1_done", dn1, 1);
        chk("nc1_hit", h1, 0);
        chk("nc1_timeout", to1, 0);
        @(negedge clk);
        chk("nc1_idle", rdy1, 1);

        // core 1 hits at edge 3
        r = '{NEVER, 3, NEVER, NEVER};
        h = '{0, 1, 0, 0};
        d = '{32'h1, 32'hDEADBEEF, 32'h3, 32'h4};
        run(0, 0, 32'h100, r, h, d, 2, 1);
        // three misses on separate edges
        r = '{2, 4, NEVER, 6};
        h = '{0, 0, 1, 0};
        run(2, 0, 32'h200, r, h, d, 5, 1);
        // write, only cores 0 and 2 acknowledge
        r = '{2, NEVER, 3, NEVER};
        h = '{1, 0, 1, 0};
        run(1, 1, 32'h300, r, h, d, 3, 1);
        // two hits on one edge
        r = '{NEVER, 4, NEVER, 4};
        h = '{0, 1, 0, 1};
        d = '{32'h11, 32'hAAAA0001, 32'h33, 32'hBBBB0003};
        run(0, 0, 32'h400, r, h, d, 2, 1);
        // hit on the timeout edge
        r = '{TO, NEVER, NEVER, NEVER};
        h = '{1, 0, 0, 0};
        run(2, 0, 32'h500, r, h, d, 2, 1);
        // write with hits: all acknowledged, memory path
        r = '{1, 2, 3, 1};
        h = '{1, 1, 1, 1};
        run(3, 1, 32'h600, r, h, d, 1, 1);

        // reset during MEM aborts with no completion
        r = '{NEVER, NEVER, NEVER, NEVER};
        h = '{0, 0, 0, 0};
        run(1, 1, 32'h700, r, h, d, 0, 0);
        n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_in_mem", mem_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_mem_req", mem_req, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", ready, 0);
        chk("abort_snoop_adr", snoop_adr, 0);
        chk("abort_timeout", to_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", ready, 1);

        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < NC; i++) begin
                r[i] = $urandom_range(1, TO + 3);
                h[i] = ($urandom_range(0, 3) == 0);
                d[i] = $urandom;
            end
            run($urandom_range(0, NC - 1), 1'($urandom_range(0, 1)), $urandom,
                r, h, d, $urandom_range(1, 5), 1);
        end

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending completions expected 0", q.size());
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
